// File: rtl/instruction_fetch_stage.sv
// Instruction-fetch stage: owns the PC, presents it as the fetch address and
// captures {pc, pc+step, instruction} into the IF/ID register every cycle.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'd64,
    parameter logic [31:0] PC_STEP    = 32'd4,
    parameter logic [31:0] FLUSH_DATA = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        control_j,
    input  logic [31:0] pc_j,
    input  logic [31:0] ins_data,
    output logic [31:0] ins_addr,
    output logic [31:0] pipe_pc,
    output logic [31:0] pipe_pc4,
    output logic [31:0] pipe_data
);

    logic [31:0] pc;
    logic [31:0] pc_seq;

    // Wraps modulo 2^32 by construction of the 32-bit sum.
    assign pc_seq   = pc + PC_STEP;
    assign ins_addr = pc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc        <= RESET_PC;
            pipe_pc   <= 32'd0;
            pipe_pc4  <= 32'd0;
            pipe_data <= 32'd0;
        end else begin
            pipe_pc  <= pc;
            pipe_pc4 <= pc_seq;
            // A redirect squashes the word fetched this cycle into a bubble.
            if (control_j) begin
                pipe_data <= FLUSH_DATA;
                pc        <= pc_j;
            end else begin
                pipe_data <= ins_data;
                pc        <= pc_seq;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage: table of per-edge vectors plus
// hand-written reset, wrap and held-jump sequences.
module tb_instruction_fetch_stage;

    logic        clk;
    logic        reset_n;
    logic        control_j;
    logic [31:0] pc_j;
    logic [31:0] ins_data;
    logic [31:0] ins_addr;
    logic [31:0] pipe_pc;
    logic [31:0] pipe_pc4;
    logic [31:0] pipe_data;

    int checks;
    int failures;

    logic [127:0] exp_q[$];

    typedef struct {
        logic        j;
        logic [31:0] target;
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[5];

    instruction_fetch_stage #(
        .RESET_PC  (32'd64),
        .PC_STEP   (32'd4),
        .FLUSH_DATA(32'h0000_0000)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .control_j(control_j),
        .pc_j     (pc_j),
        .ins_data (ins_data),
        .ins_addr (ins_addr),
        .pipe_pc  (pipe_pc),
        .pipe_pc4 (pipe_pc4),
        .pipe_data(pipe_data)
    );

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory model: distinct word per address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_5A5A;
    endfunction

    assign ins_data = mem_word(ins_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_state(input logic [31:0] a, input logic [31:0] p,
                                input logic [31:0] p4, input logic [31:0] d);
        exp_q.push_back({a, p, p4, d});
    endtask

    // Scoreboard: pop the oldest expectation and compare all four outputs.
    task automatic compare_state(input string tag);
        logic [127:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = exp_q.pop_front();
        check({tag, ".ins_addr"},  ins_addr,  e[127:96]);
        check({tag, ".pipe_pc"},   pipe_pc,   e[95:64]);
        check({tag, ".pipe_pc4"},  pipe_pc4,  e[63:32]);
        check({tag, ".pipe_data"}, pipe_data, e[31:0]);
    endtask

    // Driver: set inputs, take one rising edge, sample 1 ns later.
    task automatic drive_edge(input logic j, input logic [31:0] target);
        control_j = j;
        pc_j      = target;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        control_j = 1'b0;
        pc_j      = 32'd0;
        reset_n   = 1'b0;

        vecs[0] = '{1'b0, 32'd0,   32'd68,  32'd64,  32'd68,  mem_word(32'd64)};
        vecs[1] = '{1'b0, 32'd0,   32'd72,  32'd68,  32'd72,  mem_word(32'd68)};
        vecs[2] = '{1'b1, 32'd112, 32'd112, 32'd72,  32'd76,  32'd0};
        vecs[3] = '{1'b0, 32'd0,   32'd116, 32'd112, 32'd116, mem_word(32'd112)};
        vecs[4] = '{1'b0, 32'd0,   32'd120, 32'd116, 32'd120, mem_word(32'd116)};

        // Reset held across edges, released between edges.
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        expect_state(32'd64, 32'd0, 32'd0, 32'd0);
        compare_state("reset");

        for (int i = 0; i < 5; i++) begin
            drive_edge(vecs[i].j, vecs[i].target);
            expect_state(vecs[i].addr, vecs[i].pc, vecs[i].pc4, vecs[i].data);
            compare_state($sformatf("vec%0d", i));
        end
        control_j = 1'b0;

        // Asynchronous reset mid-cycle with PC=120.
        check("pre_async.ins_addr", ins_addr, 32'd120);
        reset_n = 1'b0;
        #1;
        expect_state(32'd64, 32'd0, 32'd0, 32'd0);
        compare_state("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        drive_edge(1'b0, 32'd0);
        expect_state(32'd68, 32'd64, 32'd68, mem_word(32'd64));
        compare_state("post_reset");

        // Wrap: jump to 0xFFFFFFFC, then sequential edges.
        drive_edge(1'b1, 32'hFFFF_FFFC);
        expect_state(32'hFFFF_FFFC, 32'd68, 32'd72, 32'd0);
        compare_state("wrap_jump");
        drive_edge(1'b0, 32'd0);
        expect_state(32'd0, 32'hFFFF_FFFC, 32'd0, mem_word(32'hFFFF_FFFC));
        compare_state("wrap_seq");
        drive_edge(1'b0, 32'd0);
        expect_state(32'd4, 32'd0, 32'd4, mem_word(32'd0));
        compare_state("wrap_seq2");

        // Jump held high; second target is unaligned and taken as-is.
        drive_edge(1'b1, 32'd200);
        expect_state(32'd200, 32'd4, 32'd8, 32'd0);
        compare_state("held_j0");
        drive_edge(1'b1, 32'd301);
        expect_state(32'd301, 32'd200, 32'd204, 32'd0);
        compare_state("held_j1");
        drive_edge(1'b0, 32'd0);
        expect_state(32'd305, 32'd301, 32'd305, mem_word(32'd301));
        compare_state("after_held");

        // Reset held low with jump requested across edges.
        @(negedge clk);
        reset_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_edge(1'b1, 32'd400);
            expect_state(32'd64, 32'd0, 32'd0, 32'd0);
            compare_state($sformatf("reset_hold%0d", k));
        end
        control_j = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        drive_edge(1'b0, 32'd0);
        expect_state(32'd68, 32'd64, 32'd68, mem_word(32'd64));
        compare_state("final_release");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
